mem_wb_skid_reg: RTL and testbench

//  MEM->WB pipeline register with valid/ready handshake, optional 2-entry skid buffer,

---
 rtl/mem_wb_skid_reg_pkg.sv | 21 ++
 rtl/mem_wb_payload_reg.sv | 26 ++
 rtl/mem_wb_skid_reg.sv | 164 ++++++++++++++++
 tb/tb_mem_wb_skid_reg.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_skid_reg_pkg.sv
// Shared definitions for the MEM->WB pipeline register: default widths,
// the hard-wired zero register address and the occupancy state encoding.
package mem_wb_skid_reg_pkg;

    localparam int unsigned DEF_DATA_WIDTH        = 32;
    localparam int unsigned DEF_INSTRUCTION_WIDTH = 32;
    localparam int unsigned DEF_REG_ADDR_WIDTH    = 5;
    localparam int unsigned DEF_NUM_FWD_PORTS     = 2;

    // r0 reads as zero and must never be written or forwarded.
    localparam int unsigned REG_ZERO = 0;

    // Bit 1 is the head-valid flag and bit 0 the skid-valid flag, so both
    // come straight off flops and in_ready never passes through logic.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_TWO   = 2'b11
    } wb_state_e;

endpackage

// File: rtl/mem_wb_payload_reg.sv
// Load/clear register holding one packed MEM->WB payload (head or skid entry).
module mem_wb_payload_reg #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Payload storage: clear wins over load so a flush also wipes the stored write enables.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the payload is reset because its outputs are visible and must read zero
        // after reset; non-blocking assignments keep the update race-free.
        if (!rst_n) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_wb_skid_reg.sv
// MEM->WB pipeline register with valid/ready handshake, optional skid entry,
// synchronous flush, r0 write suppression and EX forwarding comparators.
module mem_wb_skid_reg
    import mem_wb_skid_reg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH        = DEF_DATA_WIDTH,
    parameter int unsigned INSTRUCTION_WIDTH = DEF_INSTRUCTION_WIDTH,
    parameter int unsigned REG_ADDR_WIDTH    = DEF_REG_ADDR_WIDTH,
    parameter int unsigned SKID_EN           = 1,
    parameter int unsigned NUM_FWD_PORTS     = DEF_NUM_FWD_PORTS
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    flush,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic                                    write_back_mux_sel_in,
    input  logic [DATA_WIDTH-1:0]                   alu_data_in,
    input  logic [DATA_WIDTH-1:0]                   hi_data_in,
    input  logic [REG_ADDR_WIDTH-1:0]               reg_a_wr_addr_in,
    input  logic [REG_ADDR_WIDTH-1:0]               reg_b_wr_addr_in,
    input  logic                                    reg_a_wr_en_in,
    input  logic                                    reg_b_wr_en_in,
    input  logic [INSTRUCTION_WIDTH-1:0]            instruction_in,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic                                    write_back_mux_sel_out,
    output logic [DATA_WIDTH-1:0]                   alu_data_out,
    output logic [DATA_WIDTH-1:0]                   hi_data_out,
    output logic [REG_ADDR_WIDTH-1:0]               reg_a_wr_addr_out,
    output logic [REG_ADDR_WIDTH-1:0]               reg_b_wr_addr_out,
    output logic                                    reg_a_wr_en_out,
    output logic                                    reg_b_wr_en_out,
    output logic [INSTRUCTION_WIDTH-1:0]            instruction_out,
    input  logic [NUM_FWD_PORTS*REG_ADDR_WIDTH-1:0] fwd_rd_addr,
    output logic [NUM_FWD_PORTS-1:0]                fwd_hit,
    output logic [NUM_FWD_PORTS*DATA_WIDTH-1:0]     fwd_data
);

    localparam int unsigned PW = 1 + 2*DATA_WIDTH + 2*REG_ADDR_WIDTH + 2 + INSTRUCTION_WIDTH;
    localparam logic [REG_ADDR_WIDTH-1:0] ZERO_ADDR = REG_ADDR_WIDTH'(REG_ZERO);

    wb_state_e         state, state_next;
    logic              skid_valid;
    logic              accept, drain;
    logic              head_load, skid_load, head_from_skid;
    logic              stored_a_en, stored_b_en;
    logic [PW-1:0]     in_payload, head_d, head_q, skid_q;

    assign out_valid  = state[1];
    assign skid_valid = state[0];
    assign accept     = in_valid & in_ready & ~flush;
    assign drain      = out_valid & out_ready;

    // Enables are qualified at capture so a write to r0 never becomes visible downstream.
    assign in_payload = {write_back_mux_sel_in, alu_data_in, hi_data_in,
                         reg_a_wr_addr_in, reg_b_wr_addr_in,
                         reg_a_wr_en_in & (reg_a_wr_addr_in != ZERO_ADDR),
                         reg_b_wr_en_in & (reg_b_wr_addr_in != ZERO_ADDR),
                         instruction_in};

    assign head_d = head_from_skid ? skid_q : in_payload;

    assign {write_back_mux_sel_out, alu_data_out, hi_data_out,
            reg_a_wr_addr_out, reg_b_wr_addr_out,
            stored_a_en, stored_b_en, instruction_out} = head_q;

    assign reg_a_wr_en_out = stored_a_en & out_valid;
    assign reg_b_wr_en_out = stored_b_en & out_valid;

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next occupancy and entry load strobes; flush overrides every transfer.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_next     = state;
        head_load      = 1'b0;
        skid_load      = 1'b0;
        head_from_skid = 1'b0;
        if (flush) begin
            state_next = ST_EMPTY;
        end else if (SKID_EN != 0) begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_next = ST_ONE;
                        head_load  = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        head_load = 1'b1;
                    end else if (accept) begin
                        state_next = ST_TWO;
                        skid_load  = 1'b1;
                    end else if (drain) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (drain) begin
                        state_next     = ST_ONE;
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                    end
                end
                default: state_next = ST_EMPTY;
            endcase
        end else begin
            if (accept) begin
                state_next = ST_ONE;
                head_load  = 1'b1;
            end else if (drain) begin
                state_next = ST_EMPTY;
            end
        end
    end

    mem_wb_payload_reg #(.WIDTH(PW)) u_head (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (head_load),
        .clear (flush),
        .d     (head_d),
        .q     (head_q)
    );

    if (SKID_EN != 0) begin : g_skid
        mem_wb_payload_reg #(.WIDTH(PW)) u_skid (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (skid_load),
            .clear (flush),
            .d     (in_payload),
            .q     (skid_q)
        );
        // Ready depends only on a flop, breaking the combinational ready path to MEM.
        assign in_ready = ~skid_valid;
    end else begin : g_no_skid
        assign skid_q   = '0;
        assign in_ready = ~out_valid | out_ready;
    end

    // Per-port forwarding from the head entry; port B wins when both match.
    // rd==0 cannot hit because stored enables are already cleared for r0.
    for (genvar i = 0; i < int'(NUM_FWD_PORTS); i++) begin : g_fwd
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      hit_a, hit_b;
        assign rd    = fwd_rd_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        assign hit_b = out_valid & stored_b_en & (reg_b_wr_addr_out == rd);
        assign hit_a = out_valid & stored_a_en & ~write_back_mux_sel_out & (reg_a_wr_addr_out == rd);
        assign fwd_hit[i] = hit_a | hit_b;
        assign fwd_data[i*DATA_WIDTH +: DATA_WIDTH] = hit_b ? hi_data_out :
                                                      hit_a ? alu_data_out : '0;
    end

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Self-checking bench for mem_wb_skid_reg: directed corner cases on the skid
// variant, a forwarding vector table, and a scoreboarded random run on both
// the skid (instance 0) and no-skid (instance 1) variants.
`timescale 1ns/1ps
module tb_mem_wb_skid_reg;

    typedef struct packed {
        logic        sel;
        logic [31:0] alu;
        logic [31:0] hi;
        logic [4:0]  a_addr;
        logic [4:0]  b_addr;
        logic        a_en;
        logic        b_en;
        logic [31:0] instr;
    } pay_t;

    typedef struct {
        logic        sel;
        logic [31:0] alu;
        logic [31:0] hi;
        logic [4:0]  aa;
        logic [4:0]  ba;
        logic        ae;
        logic        be;
        logic [4:0]  rd;
        logic        exp_hit;
        logic [31:0] exp_data;
    } fv_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        in_valid[2], out_ready[2], flush[2];
    pay_t        pin[2];
    logic        in_ready[2], out_valid[2];
    logic        sel_o[2], ae_o[2], be_o[2];
    logic [31:0] alu_o[2], hi_o[2], instr_o[2];
    logic [4:0]  aa_o[2], ba_o[2];
    logic [9:0]  rd_addr[2];
    logic [1:0]  hit[2];
    logic [63:0] fdata[2];

    int   checks = 0;
    int   errors = 0;
    pay_t q0[$];
    pay_t q1[$];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_wb_skid_reg #(
            .DATA_WIDTH        (32),
            .INSTRUCTION_WIDTH (32),
            .REG_ADDR_WIDTH    (5),
            .SKID_EN           ((g == 0) ? 1 : 0),
            .NUM_FWD_PORTS     (2)
        ) u_dut (
            .clk                    (clk),
            .rst_n                  (rst_n),
            .flush                  (flush[g]),
            .in_valid               (in_valid[g]),
            .in_ready               (in_ready[g]),
            .write_back_mux_sel_in  (pin[g].sel),
            .alu_data_in            (pin[g].alu),
            .hi_data_in             (pin[g].hi),
            .reg_a_wr_addr_in       (pin[g].a_addr),
            .reg_b_wr_addr_in       (pin[g].b_addr),
            .reg_a_wr_en_in         (pin[g].a_en),
            .reg_b_wr_en_in         (pin[g].b_en),
            .instruction_in         (pin[g].instr),
            .out_valid              (out_valid[g]),
            .out_ready              (out_ready[g]),
            .write_back_mux_sel_out (sel_o[g]),
            .alu_data_out           (alu_o[g]),
            .hi_data_out            (hi_o[g]),
            .reg_a_wr_addr_out      (aa_o[g]),
            .reg_b_wr_addr_out      (ba_o[g]),
            .reg_a_wr_en_out        (ae_o[g]),
            .reg_b_wr_en_out        (be_o[g]),
            .instruction_out        (instr_o[g]),
            .fwd_rd_addr            (rd_addr[g]),
            .fwd_hit                (hit[g]),
            .fwd_data               (fdata[g])
        );
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic pay_t get_out(input int k);
        pay_t p;
        p.sel    = sel_o[k];
        p.alu    = alu_o[k];
        p.hi     = hi_o[k];
        p.a_addr = aa_o[k];
        p.b_addr = ba_o[k];
        p.a_en   = ae_o[k];
        p.b_en   = be_o[k];
        p.instr  = instr_o[k];
        return p;
    endfunction

    function automatic pay_t mk(input logic [31:0] alu, input logic [4:0] aa, input logic ae);
        pay_t p;
        p        = '0;
        p.alu    = alu;
        p.a_addr = aa;
        p.a_en   = ae;
        p.instr  = ~alu;
        return p;
    endfunction

    // Expected stored form of an accepted beat: r0 writes are dropped.
    function automatic pay_t masked(input pay_t p);
        pay_t m;
        m      = p;
        m.a_en = p.a_en & (p.a_addr != 5'd0);
        m.b_en = p.b_en & (p.b_addr != 5'd0);
        return m;
    endfunction

    function automatic logic [32:0] fwd_exp(input pay_t h, input logic v, input logic [4:0] rd);
        logic hb, ha;
        hb = v & h.b_en & (h.b_addr == rd);
        ha = v & h.a_en & ~h.sel & (h.a_addr == rd);
        return {ha | hb, hb ? h.hi : (ha ? h.alu : 32'h0)};
    endfunction

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic pay_t qfront(input int k);
        if (qsize(k) == 0) return '0;
        return (k == 0) ? q0[0] : q1[0];
    endfunction

    function automatic void qpush(input int k, input pay_t p);
        if (k == 0) q0.push_back(p); else q1.push_back(p);
    endfunction

    function automatic void qpop(input int k);
        if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    endfunction

    function automatic void qclear(input int k);
        if (k == 0) q0.delete(); else q1.delete();
    endfunction

    task automatic idle_inputs();
        for (int k = 0; k < 2; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
            flush[k]     = 1'b0;
            pin[k]       = '0;
            rd_addr[k]   = '0;
        end
    endtask

    fv_t vec[8];

    initial begin
        vec[0] = '{1'b0, 32'h55, 32'h77, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 32'h77};
        vec[1] = '{1'b1, 32'h55, 32'h77, 5'd5, 5'd5, 1'b1, 1'b0, 5'd5, 1'b0, 32'h0};
        vec[2] = '{1'b0, 32'h55, 32'h77, 5'd5, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 32'h55};
        vec[3] = '{1'b0, 32'h11, 32'h22, 5'd7, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 32'h22};
        vec[4] = '{1'b0, 32'h11, 32'h22, 5'd7, 5'd9, 1'b1, 1'b1, 5'd8, 1'b0, 32'h0};
        vec[5] = '{1'b0, 32'h33, 32'h44, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 32'h0};
        vec[6] = '{1'b1, 32'h66, 32'h88, 5'd4, 5'd6, 1'b1, 1'b1, 5'd6, 1'b1, 32'h88};
        vec[7] = '{1'b1, 32'h66, 32'h88, 5'd4, 5'd6, 1'b1, 1'b1, 5'd4, 1'b0, 32'h0};

        rst_n = 1'b0;
        idle_inputs();
        rd_addr[0] = {5'd5, 5'd1};
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_out_valid", out_valid[0], 1'b0);
        check("reset_in_ready", in_ready[0], 1'b1);
        check("reset_payload", get_out(0), 109'd0);
        check("reset_fwd_hit", hit[0], 2'b00);
        check("reset_in_ready_noskid", in_ready[1], 1'b1);

        // Single beat, one-cycle latency.
        @(negedge clk);
        rst_n        = 1'b1;
        pin[0]       = mk(32'h1234, 5'd3, 1'b1);
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        #1;
        check("single_out_valid", out_valid[0], 1'b1);
        check("single_a_en", ae_o[0], 1'b1);
        check("single_alu", alu_o[0], 32'h1234);
        check("single_a_addr", aa_o[0], 5'd3);
        @(negedge clk);
        #1;
        check("single_drained", out_valid[0], 1'b0);

        // Two beats into a stalled stage fill head and skid, then drain in order.
        out_ready[0] = 1'b0;
        pin[0]       = mk(32'hA, 5'd1, 1'b1);
        in_valid[0]  = 1'b1;
        @(negedge clk);
        #1;
        check("one_in_ready", in_ready[0], 1'b1);
        pin[0] = mk(32'hB, 5'd2, 1'b1);
        @(negedge clk);
        in_valid[0] = 1'b0;
        #1;
        check("two_in_ready", in_ready[0], 1'b0);
        check("two_out_valid", out_valid[0], 1'b1);
        check("two_head_a", alu_o[0], 32'hA);
        out_ready[0] = 1'b1;
        @(negedge clk);
        #1;
        check("two_head_b", alu_o[0], 32'hB);
        check("two_ready_back", in_ready[0], 1'b1);
        @(negedge clk);
        #1;
        check("two_empty", out_valid[0], 1'b0);
        out_ready[0] = 1'b0;

        // Write to r0 is suppressed and never forwarded.
        pin[0]      = mk(32'h99, 5'd0, 1'b1);
        in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        rd_addr[0]  = '0;
        #1;
        check("r0_out_valid", out_valid[0], 1'b1);
        check("r0_a_en", ae_o[0], 1'b0);
        check("r0_fwd_hit", hit[0], 2'b00);
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;

        // Forwarding vector table, each lookup tried on port 0 then port 1.
        for (int i = 0; i < 8; i++) begin
            pin[0]        = '0;
            pin[0].sel    = vec[i].sel;
            pin[0].alu    = vec[i].alu;
            pin[0].hi     = vec[i].hi;
            pin[0].a_addr = vec[i].aa;
            pin[0].b_addr = vec[i].ba;
            pin[0].a_en   = vec[i].ae;
            pin[0].b_en   = vec[i].be;
            in_valid[0]   = 1'b1;
            @(negedge clk);
            in_valid[0] = 1'b0;
            rd_addr[0]  = {5'd0, vec[i].rd};
            #1;
            check($sformatf("fwd%0d_p0_hit", i), hit[0], {1'b0, vec[i].exp_hit});
            check($sformatf("fwd%0d_p0_data", i), fdata[0], {32'h0, vec[i].exp_data});
            rd_addr[0] = {vec[i].rd, 5'd0};
            #1;
            check($sformatf("fwd%0d_p1_hit", i), hit[0], {vec[i].exp_hit, 1'b0});
            check($sformatf("fwd%0d_p1_data", i), fdata[0], {vec[i].exp_data, 32'h0});
            out_ready[0] = 1'b1;
            @(negedge clk);
            out_ready[0] = 1'b0;
        end

        // Flush while full with input offered.
        pin[0]      = mk(32'hC1, 5'd1, 1'b1);
        pin[0].b_en = 1'b1;
        pin[0].b_addr = 5'd2;
        in_valid[0] = 1'b1;
        @(negedge clk);
        pin[0] = mk(32'hC2, 5'd3, 1'b1);
        @(negedge clk);
        pin[0]   = mk(32'hC3, 5'd4, 1'b1);
        flush[0] = 1'b1;
        @(negedge clk);
        flush[0]    = 1'b0;
        in_valid[0] = 1'b0;
        #1;
        check("flush2_out_valid", out_valid[0], 1'b0);
        check("flush2_in_ready", in_ready[0], 1'b1);
        check("flush2_a_en", ae_o[0], 1'b0);
        check("flush2_b_en", be_o[0], 1'b0);
        @(negedge clk);
        #1;
        check("flush2_stays_empty", out_valid[0], 1'b0);

        // Flush with one entry held and a beat that would otherwise be accepted.
        pin[0]      = mk(32'hD1, 5'd1, 1'b1);
        in_valid[0] = 1'b1;
        @(negedge clk);
        pin[0]   = mk(32'hD2, 5'd2, 1'b1);
        flush[0] = 1'b1;
        @(negedge clk);
        flush[0]    = 1'b0;
        in_valid[0] = 1'b0;
        #1;
        check("flush1_out_valid", out_valid[0], 1'b0);
        @(negedge clk);
        #1;
        check("flush1_input_dropped", out_valid[0], 1'b0);

        // Asynchronous reset while full.
        pin[0]      = mk(32'hE1, 5'd1, 1'b1);
        in_valid[0] = 1'b1;
        @(negedge clk);
        pin[0] = mk(32'hE2, 5'd2, 1'b1);
        @(negedge clk);
        in_valid[0] = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid[0], 1'b0);
        check("async_rst_in_ready", in_ready[0], 1'b1);
        check("async_rst_alu", alu_o[0], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // No-skid variant: ready follows out_ready combinationally when full.
        pin[1]      = mk(32'hF1, 5'd1, 1'b1);
        in_valid[1] = 1'b1;
        @(negedge clk);
        #1;
        check("noskid_full_not_ready", in_ready[1], 1'b0);
        check("noskid_out_valid", out_valid[1], 1'b1);
        out_ready[1] = 1'b1;
        #1;
        check("noskid_comb_ready", in_ready[1], 1'b1);
        pin[1] = mk(32'hF2, 5'd2, 1'b1);
        @(negedge clk);
        in_valid[1] = 1'b0;
        #1;
        check("noskid_passthrough", alu_o[1], 32'hF2);
        @(negedge clk);
        #1;
        check("noskid_empty", out_valid[1], 1'b0);

        // Random traffic on both variants against a scoreboard.
        idle_inputs();
        @(negedge clk);
        for (int cyc = 0; cyc < 6000; cyc++) begin
            logic ir0_pre;
            ir0_pre = in_ready[0];
            for (int k = 0; k < 2; k++) begin
                pay_t p;
                pay_t h;
                p.sel    = 1'($urandom);
                p.alu    = $urandom;
                p.hi     = $urandom;
                p.a_addr = 5'($urandom_range(0, 7));
                p.b_addr = 5'($urandom_range(0, 7));
                p.a_en   = 1'($urandom);
                p.b_en   = 1'($urandom);
                p.instr  = 32'(cyc * 2 + k);
                pin[k]       = p;
                in_valid[k]  = ($urandom_range(0, 3) != 0);
                out_ready[k] = ($urandom_range(0, 2) != 0);
                flush[k]     = ($urandom_range(0, 63) == 0);
                h = qfront(k);
                rd_addr[k] = {5'($urandom_range(0, 7)),
                              ($urandom_range(0, 1) == 0) ? h.a_addr : h.b_addr};
            end
            #1;
            check("rnd_in_ready_registered", in_ready[0], ir0_pre);
            for (int k = 0; k < 2; k++) begin
                int          sz;
                pay_t        h;
                logic [32:0] f0, f1;
                sz = qsize(k);
                h  = qfront(k);
                check($sformatf("rnd%0d_out_valid", k), out_valid[k], sz != 0);
                check($sformatf("rnd%0d_in_ready", k), in_ready[k],
                      (k == 0) ? (sz < 2) : ((sz == 0) || out_ready[k]));
                f0 = fwd_exp(h, sz != 0, rd_addr[k][4:0]);
                f1 = fwd_exp(h, sz != 0, rd_addr[k][9:5]);
                check($sformatf("rnd%0d_fwd_hit", k), hit[k], {f1[32], f0[32]});
                check($sformatf("rnd%0d_fwd_data", k), fdata[k], {f1[31:0], f0[31:0]});
                if (out_valid[k] && out_ready[k]) begin
                    if (sz == 0) begin
                        check($sformatf("rnd%0d_underflow", k), 1'b1, 1'b0);
                    end else begin
                        check($sformatf("rnd%0d_payload", k), get_out(k), h);
                        qpop(k);
                    end
                end
                if (flush[k]) begin
                    qclear(k);
                end else if (in_valid[k] && in_ready[k]) begin
                    qpush(k, masked(pin[k]));
                end
            end
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
